// File: rtl/uart_ram_dump.sv
// RAM-to-UART readback engine: streams word_cnt RAM words into the TX FIFO, LSB byte first.
// Optional trailing 8-bit checksum byte when UART_DUMP_CSUM_EN is defined.
module uart_ram_dump #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RAM_ADDR_LEN = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [RAM_ADDR_LEN-1:0] start_addr,
  input  logic [RAM_ADDR_LEN:0]   word_cnt,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_rd_en,
  output logic [RAM_ADDR_LEN-1:0] ram_addr,
  input  logic [XLEN-1:0]         ram_rd_data,
  output logic                    tx_wr_req,
  output logic [7:0]              tx_wr_data,
  input  logic                    tx_wr_ready
);

  localparam int unsigned CNT_W = RAM_ADDR_LEN + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_SEND = 3'd3,
`ifdef UART_DUMP_CSUM_EN
    S_CSUM = 3'd4,
`endif
    S_FIN  = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [RAM_ADDR_LEN-1:0] r_addr;
  logic [CNT_W-1:0]        r_remaining;
  logic [XLEN-1:0]         r_shift;
  logic [1:0]              r_byte_idx;
`ifdef UART_DUMP_CSUM_EN
  logic [7:0]              r_csum;
`endif
  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_last_byte;

  assign w_accept    = (r_state == S_IDLE) && start && !abort;
  assign w_xfer      = tx_wr_req && tx_wr_ready;
  assign w_last_byte = (r_byte_idx == 2'd3);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort in SEND/CSUM waits for the pending byte to transfer
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (word_cnt == '0) ? S_FIN : S_RD;
      S_RD:   w_next = abort ? S_IDLE : S_WT;
      S_WT:   w_next = abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (w_xfer) begin
          if (abort)                               w_next = S_IDLE;
          else if (w_last_byte && r_remaining != CNT_W'(1)) w_next = S_RD;
`ifdef UART_DUMP_CSUM_EN
          else if (w_last_byte)                    w_next = S_CSUM;
`else
          else if (w_last_byte)                    w_next = S_FIN;
`endif
        end
      end
`ifdef UART_DUMP_CSUM_EN
      S_CSUM: if (w_xfer) w_next = abort ? S_IDLE : S_FIN;
`endif
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: address, word counter, byte shifter and running checksum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_shift     <= '0;
      r_byte_idx  <= '0;
`ifdef UART_DUMP_CSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr      <= start_addr;
            r_remaining <= word_cnt;
`ifdef UART_DUMP_CSUM_EN
            r_csum      <= '0;
`endif
          end
        end
        S_WT: begin
          r_shift    <= ram_rd_data;
          r_byte_idx <= '0;
        end
        S_SEND: begin
          if (w_xfer) begin
            r_shift    <= r_shift >> 8;
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef UART_DUMP_CSUM_EN
            r_csum     <= r_csum + r_shift[7:0];
`endif
            if (w_last_byte && r_remaining != CNT_W'(1)) begin
              r_remaining <= r_remaining - CNT_W'(1);
              r_addr      <= r_addr + RAM_ADDR_LEN'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state; all zero while reset holds the FSM in IDLE
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    ram_rd_en  = 1'b0;
    ram_addr   = '0;
    tx_wr_req  = 1'b0;
    tx_wr_data = 8'h00;
    busy = (r_state != S_IDLE);
    case (r_state)
      S_RD: begin
        ram_rd_en = 1'b1;
        ram_addr  = r_addr;
      end
      S_SEND: begin
        tx_wr_req  = 1'b1;
        tx_wr_data = r_shift[7:0];
      end
`ifdef UART_DUMP_CSUM_EN
      S_CSUM: begin
        tx_wr_req  = 1'b1;
        tx_wr_data = r_csum;
      end
`endif
      S_FIN: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_ram_dump.sv
// Directed self-checking bench for uart_ram_dump; checksum expectations follow UART_DUMP_CSUM_EN.
module tb_uart_ram_dump;

  localparam int unsigned AW = 14;
`ifdef UART_DUMP_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_cnt = '0;
  logic          abort = 1'b0;
  logic          busy, done, ram_rd_en, tx_wr_req;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rd_data;
  logic [7:0]    tx_wr_data;
  logic          tx_wr_ready = 1'b1;

  logic [31:0]   mem [0:(1<<AW)-1];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;

  logic [7:0]    bytes_q[$];
  int            byte_cyc_q[$];
  logic [AW-1:0] rd_addr_q[$];
  int            rd_cyc_q[$];
  int            done_cnt;
  int            done_cyc;
  bit            overlap;

  uart_ram_dump #(.XLEN(32), .RAM_ADDR_LEN(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .word_cnt(word_cnt),
    .abort(abort), .busy(busy), .done(done), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_rd_data(ram_rd_data), .tx_wr_req(tx_wr_req), .tx_wr_data(tx_wr_data),
    .tx_wr_ready(tx_wr_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_addr];

  // Passive monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_wr_req && tx_wr_ready) begin
        bytes_q.push_back(tx_wr_data);
        byte_cyc_q.push_back(cyc);
      end
      if (ram_rd_en) begin
        rd_addr_q.push_back(ram_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ram_rd_en && tx_wr_req) overlap = 1'b1;
    end
  end

  task automatic clear_mon();
    bytes_q.delete(); byte_cyc_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; overlap = 1'b0;
  endtask

  task automatic kick(input logic [AW-1:0] a, input logic [AW:0] n, output int sc);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; word_cnt = n; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, ram_rd_en, ram_addr, tx_wr_req, tx_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {busy, done, ram_rd_en, ram_addr, tx_wr_req, tx_wr_data});
    end
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic test_basic();
    int sc; bit to;
    logic [7:0] exp[$];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    if (CS != 0) exp.push_back(8'h64);
    clear_mon();
    kick(14'h0010, 15'd2, sc);
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout busy stuck"); end
    total++;
    if (bytes_q.size() != exp.size()) begin
      bad++; $display("FAIL basic_len got=%0d want=%0d", bytes_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < bytes_q.size(); i++) begin
      total++;
      if (bytes_q[i] !== exp[i]) begin
        bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, bytes_q[i], exp[i]);
      end
    end
    total++;
    if (rd_cyc_q.size() != 2) begin
      bad++; $display("FAIL basic_rd_count got=%0d want=2", rd_cyc_q.size());
    end else begin
      total++;
      if (rd_cyc_q[0] - sc !== 1 || rd_cyc_q[1] - sc !== 7) begin
        bad++; $display("FAIL basic_rd_timing got=%0d,%0d want=1,7", rd_cyc_q[0] - sc, rd_cyc_q[1] - sc);
      end
      total++;
      if (rd_addr_q[0] !== 14'h0010 || rd_addr_q[1] !== 14'h0011) begin
        bad++; $display("FAIL basic_rd_addr got=%h,%h want=0010,0011", rd_addr_q[0], rd_addr_q[1]);
      end
    end
    if (byte_cyc_q.size() > 0) begin
      total++;
      if (byte_cyc_q[0] - sc !== 3) begin
        bad++; $display("FAIL basic_first_req got=%0d want=3", byte_cyc_q[0] - sc);
      end
      total++;
      if (done_cyc - byte_cyc_q[byte_cyc_q.size()-1] !== 1) begin
        bad++; $display("FAIL basic_done_after_last got=%0d want=1", done_cyc - byte_cyc_q[byte_cyc_q.size()-1]);
      end
    end
    total++;
    if (done_cnt !== 1 || done_cyc - sc !== 13 + CS) begin
      bad++; $display("FAIL basic_done got cnt=%0d at=%0d want cnt=1 at=%0d", done_cnt, done_cyc - sc, 13 + CS);
    end
    total++;
    if (overlap !== 1'b0) begin bad++; $display("FAIL basic_overlap got=1 want=0"); end
  endtask

  task automatic test_backpressure();
    int sc; bit to;
    logic [7:0] exp[$];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    if (CS != 0) exp.push_back(8'h64);
    clear_mon();
    kick(14'h0010, 15'd2, sc);
    goto_cycle(sc + 5);
    tx_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (tx_wr_req !== 1'b1 || tx_wr_data !== 8'h33) begin
        bad++; $display("FAIL bp_stall%0d got req=%b data=%h want req=1 data=33", i, tx_wr_req, tx_wr_data);
      end
      @(posedge clk);
    end
    #1 tx_wr_ready = 1'b1;
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL bp_timeout busy stuck"); end
    total++;
    if (bytes_q.size() != exp.size()) begin
      bad++; $display("FAIL bp_len got=%0d want=%0d", bytes_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < bytes_q.size(); i++) begin
      total++;
      if (bytes_q[i] !== exp[i]) begin
        bad++; $display("FAIL bp_byte%0d got=%h want=%h", i, bytes_q[i], exp[i]);
      end
    end
    total++;
    if (done_cnt !== 1 || done_cyc - sc !== 18 + CS) begin
      bad++; $display("FAIL bp_done got cnt=%0d at=%0d want cnt=1 at=%0d", done_cnt, done_cyc - sc, 18 + CS);
    end
  endtask

  task automatic test_wrap();
    int sc; bit to;
    logic [7:0] exp[$];
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    if (CS != 0) exp.push_back(8'h18);
    clear_mon();
    kick(14'h3FFF, 15'd2, sc);
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL wrap_timeout busy stuck"); end
    total++;
    if (rd_addr_q.size() != 2) begin
      bad++; $display("FAIL wrap_rd_count got=%0d want=2", rd_addr_q.size());
    end else begin
      total++;
      if (rd_addr_q[0] !== 14'h3FFF || rd_addr_q[1] !== 14'h0000) begin
        bad++; $display("FAIL wrap_addr got=%h,%h want=3fff,0000", rd_addr_q[0], rd_addr_q[1]);
      end
    end
    total++;
    if (bytes_q.size() != exp.size()) begin
      bad++; $display("FAIL wrap_len got=%0d want=%0d", bytes_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < bytes_q.size(); i++) begin
      total++;
      if (bytes_q[i] !== exp[i]) begin
        bad++; $display("FAIL wrap_byte%0d got=%h want=%h", i, bytes_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_zero();
    int sc; bit to;
    clear_mon();
    kick(14'h0020, 15'd0, sc);
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL zero_timeout busy stuck"); end
    total++;
    if (rd_addr_q.size() != 0 || bytes_q.size() != 0) begin
      bad++; $display("FAIL zero_traffic got rd=%0d bytes=%0d want 0,0", rd_addr_q.size(), bytes_q.size());
    end
    total++;
    if (done_cnt !== 1 || done_cyc - sc !== 1) begin
      bad++; $display("FAIL zero_done got cnt=%0d at=%0d want cnt=1 at=1", done_cnt, done_cyc - sc);
    end
  endtask

  task automatic test_abort();
    int sc; bit to;
    logic [7:0] exp[$];
    clear_mon();
    kick(14'h0010, 15'd2, sc);
    goto_cycle(sc + 4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (bytes_q.size() != 2) begin
      bad++; $display("FAIL abort_len got=%0d want=2", bytes_q.size());
    end else begin
      total++;
      if (bytes_q[0] !== 8'h11 || bytes_q[1] !== 8'h22) begin
        bad++; $display("FAIL abort_bytes got=%h,%h want=11,22", bytes_q[0], bytes_q[1]);
      end
    end
    total++;
    if (done_cnt !== 0 || rd_addr_q.size() != 1) begin
      bad++; $display("FAIL abort_quiet got done=%0d rd=%0d want 0,1", done_cnt, rd_addr_q.size());
    end
    exp = '{8'h55, 8'h66, 8'h77, 8'h88};
    if (CS != 0) exp.push_back(8'hBA);
    clear_mon();
    kick(14'h0011, 15'd1, sc);
    wait_idle(to);
    total++;
    if (to || done_cnt !== 1 || bytes_q.size() != exp.size()) begin
      bad++; $display("FAIL abort_restart got to=%b done=%0d len=%0d want 0,1,%0d", to, done_cnt, bytes_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < bytes_q.size(); i++) begin
      total++;
      if (bytes_q[i] !== exp[i]) begin
        bad++; $display("FAIL abort_restart_byte%0d got=%h want=%h", i, bytes_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int sc;
    clear_mon();
    kick(14'h0010, 15'd2, sc);
    goto_cycle(sc + 3);
    start = 1'b1; start_addr = 14'h0030; word_cnt = 15'd5;
    @(posedge clk); #1;
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, ram_rd_en, ram_addr, tx_wr_req, tx_wr_data} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs got=%b want=0", {busy, done, ram_rd_en, ram_addr, tx_wr_req, tx_wr_data});
    end
    total++;
    if (bytes_q.size() != 1 || rd_addr_q.size() != 1) begin
      bad++; $display("FAIL rst_mid_pre got bytes=%0d rd=%0d want 1,1", bytes_q.size(), rd_addr_q.size());
    end else begin
      total++;
      if (bytes_q[0] !== 8'h11 || rd_addr_q[0] !== 14'h0010) begin
        bad++; $display("FAIL rst_mid_pre_data got=%h,%h want=11,0010", bytes_q[0], rd_addr_q[0]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || bytes_q.size() != 0 || rd_addr_q.size() != 0 || done_cnt != 0) begin
      bad++; $display("FAIL rst_mid_idle got busy=%b bytes=%0d rd=%0d done=%0d want 0,0,0,0",
                      busy, bytes_q.size(), rd_addr_q.size(), done_cnt);
    end
  endtask

  initial begin
    mem[14'h0010] = 32'h44332211;
    mem[14'h0011] = 32'h88776655;
    mem[14'h3FFF] = 32'hDDCCBBAA;
    mem[14'h0000] = 32'h04030201;
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
